// File: rtl/io_channel_hub.sv
// io_channel_hub: multi-channel device I/O hub. Each channel has an input FIFO
// filled on enter_in rising edges and an output handshake FSM, and the CPU reaches
// one channel per access through a single read/write port.
// Optional feature macro: IO_HUB_TIMEOUT_EN. It aborts output handshakes that
// stall for TIMEOUT cycles and flags them on 'timeout'.
module io_channel_hub #(
  parameter int CH_W    = 2,
  parameter int DATA_W  = 32,
  parameter int DEPTH_W = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [(1<<CH_W)*DATA_W-1:0]  dev_in,
  input  logic [(1<<CH_W)-1:0]         enter_in,
  output logic [(1<<CH_W)*DATA_W-1:0]  dev_out,
  output logic [(1<<CH_W)-1:0]         enter_out,
  input  logic [(1<<CH_W)-1:0]         done_out,
  input  logic [CH_W-1:0]              cpu_chan,
  input  logic                         cpu_rd,
  input  logic                         cpu_wr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_rvalid,
  output logic                         wr_err,
  output logic [(1<<CH_W)-1:0]         in_ready,
  output logic [(1<<CH_W)-1:0]         out_ready,
  output logic [(1<<CH_W)-1:0]         overflow,
  output logic [(1<<CH_W)-1:0]         timeout
);
  localparam int CHANNELS = 1 << CH_W;
  localparam int DEPTH    = 1 << DEPTH_W;
  localparam int PTR_W    = DEPTH_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_RELEASE} outState_e;

  if (TIMEOUT < 1) begin : gBadTimeout
    $error("io_channel_hub: TIMEOUT must be at least 1");
  end

  logic [CHANNELS-1:0]              enterPrev_q;
  logic [CHANNELS-1:0]              inEdge;
  logic [DATA_W-1:0]                fifoMem_q [CHANNELS][DEPTH];
  logic [CHANNELS-1:0][PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CHANNELS-1:0]              push, pop, full, empty;
  logic [CHANNELS-1:0]              overflow_q, overflow_d;
  logic [DATA_W-1:0]                cpuRdata_q, cpuRdata_d;
  logic                             cpuRvalid_q, cpuRvalid_d;
  logic                             wrErr_q, wrErr_d;
  outState_e [CHANNELS-1:0]         state_q, state_d;
  logic [CHANNELS-1:0][DATA_W-1:0]  devOut_q, devOut_d;

  assign inEdge = enter_in & ~enterPrev_q;

  // FIFO bookkeeping: full/empty decode, push/pop decisions, read data and overflow flags
  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    overflow_d  = overflow_q;
    cpuRdata_d  = cpuRdata_q;
    cpuRvalid_d = 1'b0;
    push        = '0;
    pop         = '0;
    full        = '0;
    empty       = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]  = (wrPtr_q[c][PTR_W-1] != rdPtr_q[c][PTR_W-1]) &&
                 (wrPtr_q[c][PTR_W-2:0] == rdPtr_q[c][PTR_W-2:0]);
      empty[c] = (wrPtr_q[c] == rdPtr_q[c]);
      pop[c]   = cpu_rd && (cpu_chan == CH_W'(c)) && !empty[c];
      push[c]  = inEdge[c] && (!full[c] || pop[c]);
      if (pop[c]) begin
        rdPtr_d[c]    = rdPtr_q[c] + PTR_W'(1);
        overflow_d[c] = 1'b0;
        cpuRdata_d    = fifoMem_q[c][rdPtr_q[c][PTR_W-2:0]];
        cpuRvalid_d   = 1'b1;
      end
      if (push[c]) begin
        wrPtr_d[c] = wrPtr_q[c] + PTR_W'(1);
      end
      if (inEdge[c] && !push[c]) begin
        overflow_d[c] = 1'b1;
      end
    end
  end

  // FIFO storage has no reset; emptiness is defined by the pointers alone
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (push[c]) begin
        fifoMem_q[c][wrPtr_q[c][PTR_W-2:0]] <= dev_in[c*DATA_W +: DATA_W];
      end
    end
  end

  // Input-side registers; enterPrev resets high so a level held through reset is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      enterPrev_q <= '1;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      overflow_q  <= '0;
      cpuRdata_q  <= '0;
      cpuRvalid_q <= 1'b0;
    end else begin
      enterPrev_q <= enter_in;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      overflow_q  <= overflow_d;
      cpuRdata_q  <= cpuRdata_d;
      cpuRvalid_q <= cpuRvalid_d;
    end
  end

`ifdef IO_HUB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);

  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            timeout_q, timeout_d;
`endif

  // Output handshake next-state: IDLE -> PRESENT on write, PRESENT -> RELEASE on done, back on !done
  always_comb begin
    state_d  = state_q;
    devOut_d = devOut_q;
    wrErr_d  = 1'b0;
`ifdef IO_HUB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    for (int c = 0; c < CHANNELS; c++) begin
      case (state_q[c])
        ST_IDLE: begin
          if (cpu_wr && (cpu_chan == CH_W'(c))) begin
            state_d[c]  = ST_PRESENT;
            devOut_d[c] = cpu_wdata;
`ifdef IO_HUB_TIMEOUT_EN
            cnt_d[c]     = '0;
            timeout_d[c] = 1'b0;
`endif
          end
        end
        ST_PRESENT: begin
          if (done_out[c]) begin
            state_d[c] = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!done_out[c]) begin
            state_d[c] = ST_IDLE;
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
`ifdef IO_HUB_TIMEOUT_EN
      if (state_q[c] != ST_IDLE) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
        if (cnt_d[c] == TIMEOUT_VAL) begin
          state_d[c]   = ST_IDLE;
          timeout_d[c] = 1'b1;
        end
      end
`endif
      if (cpu_wr && (cpu_chan == CH_W'(c)) && (state_q[c] != ST_IDLE)) begin
        wrErr_d = 1'b1;
      end
    end
  end

  // Output-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= ST_IDLE;
      end
      devOut_q <= '0;
      wrErr_q  <= 1'b0;
`ifdef IO_HUB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      devOut_q <= devOut_d;
      wrErr_q  <= wrErr_d;
`ifdef IO_HUB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Status outputs are pure decodes of registered state
  always_comb begin
    enter_out = '0;
    out_ready = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      enter_out[c] = (state_q[c] == ST_PRESENT);
      out_ready[c] = (state_q[c] == ST_IDLE);
    end
  end

  assign dev_out    = devOut_q;
  assign in_ready   = ~empty;
  assign overflow   = overflow_q;
  assign cpu_rdata  = cpuRdata_q;
  assign cpu_rvalid = cpuRvalid_q;
  assign wr_err     = wrErr_q;
`ifdef IO_HUB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = '0;
`endif

endmodule

// File: tb/tb_io_channel_hub.sv
// Testbench for io_channel_hub: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_io_channel_hub;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [127:0]  dev_in;
  logic [3:0]    enter_in;
  logic [127:0]  dev_out;
  logic [3:0]    enter_out;
  logic [3:0]    done_out;
  logic [1:0]    cpu_chan;
  logic          cpu_rd;
  logic          cpu_wr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          cpu_rvalid;
  logic          wr_err;
  logic [3:0]    in_ready;
  logic [3:0]    out_ready;
  logic [3:0]    overflow;
  logic [3:0]    timeout;

  int checks = 0;
  int errors = 0;

  io_channel_hub #(.CH_W(2), .DATA_W(32), .DEPTH_W(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .dev_in(dev_in), .enter_in(enter_in),
    .dev_out(dev_out), .enter_out(enter_out), .done_out(done_out),
    .cpu_chan(cpu_chan), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .wr_err(wr_err), .in_ready(in_ready), .out_ready(out_ready),
    .overflow(overflow), .timeout(timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: one queue per channel, handshake phase per channel
  logic [31:0] mq [4][$];
  logic [3:0]  mPrev;
  logic [3:0]  mOvf;
  logic [3:0]  mTmo;
  logic [31:0] mRdata;
  logic        mRvalid;
  logic        mWerr;
  int          mPhase [4];
  int          mCnt [4];
  logic [31:0] mDout [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelStep();
    logic [3:0] edges;
    int oldPh [4];
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        mPhase[c] = 0;
        mCnt[c] = 0;
        mDout[c] = '0;
      end
      mPrev = 4'hF; mOvf = '0; mTmo = '0; mRdata = '0; mRvalid = 1'b0; mWerr = 1'b0;
    end else begin
      edges = enter_in & ~mPrev;
      mPrev = enter_in;
      mRvalid = 1'b0;
      if (cpu_rd && mq[cpu_chan].size() > 0) begin
        mRdata = mq[cpu_chan].pop_front();
        mRvalid = 1'b1;
        mOvf[cpu_chan] = 1'b0;
      end
      for (int c = 0; c < 4; c++) begin
        if (edges[c]) begin
          if (mq[c].size() < 4) mq[c].push_back(dev_in[c*32 +: 32]);
          else mOvf[c] = 1'b1;
        end
      end
      for (int c = 0; c < 4; c++) oldPh[c] = mPhase[c];
      for (int c = 0; c < 4; c++) begin
        if (oldPh[c] == 1 && done_out[c]) mPhase[c] = 2;
        else if (oldPh[c] == 2 && !done_out[c]) mPhase[c] = 0;
`ifdef IO_HUB_TIMEOUT_EN
        if (oldPh[c] != 0) begin
          mCnt[c]++;
          if (mCnt[c] == TO) begin
            mPhase[c] = 0;
            mTmo[c] = 1'b1;
          end
        end
`endif
      end
      mWerr = 1'b0;
      if (cpu_wr) begin
        if (oldPh[cpu_chan] == 0) begin
          mPhase[cpu_chan] = 1;
          mDout[cpu_chan] = cpu_wdata;
          mCnt[cpu_chan] = 0;
          mTmo[cpu_chan] = 1'b0;
        end else begin
          mWerr = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] eIr, eOr, eEo;
    for (int c = 0; c < 4; c++) begin
      eIr[c] = (mq[c].size() != 0);
      eOr[c] = (mPhase[c] == 0);
      eEo[c] = (mPhase[c] == 1);
    end
    chk({tag, "/rdata"}, cpu_rdata, mRdata);
    chk({tag, "/rvalid"}, cpu_rvalid, mRvalid);
    chk({tag, "/wr_err"}, wr_err, mWerr);
    chk({tag, "/in_ready"}, in_ready, eIr);
    chk({tag, "/out_ready"}, out_ready, eOr);
    chk({tag, "/enter_out"}, enter_out, eEo);
    chk({tag, "/overflow"}, overflow, mOvf);
    chk({tag, "/timeout"}, timeout, mTmo);
    chk({tag, "/dev_out"}, dev_out, {mDout[3], mDout[2], mDout[1], mDout[0]});
  endtask

  // One clock: model consumes the current inputs, DUT is sampled 1 ns after the edge
  task automatic applyStimulus(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleInputs();
    enter_in = '0; done_out = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cpu_chan = '0; cpu_wdata = '0; dev_in = '0;
  endtask

  typedef struct {
    logic [3:0]  enIn;
    logic [31:0] din;
    logic [3:0]  done;
    logic        rd;
    logic        wr;
    logic [1:0]  chan;
    logic [31:0] wdata;
    logic        expRvalid;
    logic [31:0] expRdata;
    logic        expWrErr;
    logic [3:0]  expInReady;
    logic [3:0]  expEnterOut;
    logic [3:0]  expOutReady;
    logic [31:0] expDout3;
  } vec_t;

  vec_t vecs [13];

  initial begin
    //            enIn  din    done rd wr ch wdata         rv rdata  we  ir   eo   or   dout3
    vecs[0]  = '{4'h0, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 4'h0, 4'h0, 4'hF, 32'h0};
    vecs[1]  = '{4'h4, 32'hA1, 4'h0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 4'h4, 4'h0, 4'hF, 32'h0};
    vecs[2]  = '{4'h0, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 4'h4, 4'h0, 4'hF, 32'h0};
    vecs[3]  = '{4'h4, 32'hA2, 4'h0, 0, 0, 0, 32'h0,        0, 32'h0,  0, 4'h4, 4'h0, 4'hF, 32'h0};
    vecs[4]  = '{4'h0, 32'h0,  4'h0, 1, 0, 2, 32'h0,        1, 32'hA1, 0, 4'h4, 4'h0, 4'hF, 32'h0};
    vecs[5]  = '{4'h0, 32'h0,  4'h0, 1, 0, 2, 32'h0,        1, 32'hA2, 0, 4'h0, 4'h0, 4'hF, 32'h0};
    vecs[6]  = '{4'h0, 32'h0,  4'h0, 1, 0, 2, 32'h0,        0, 32'hA2, 0, 4'h0, 4'h0, 4'hF, 32'h0};
    vecs[7]  = '{4'h0, 32'h0,  4'h0, 0, 1, 3, 32'hDEADBEEF, 0, 32'hA2, 0, 4'h0, 4'h8, 4'h7, 32'hDEADBEEF};
    vecs[8]  = '{4'h0, 32'h0,  4'h0, 0, 1, 3, 32'h12345678, 0, 32'hA2, 1, 4'h0, 4'h8, 4'h7, 32'hDEADBEEF};
    vecs[9]  = '{4'h0, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 32'hA2, 0, 4'h0, 4'h8, 4'h7, 32'hDEADBEEF};
    vecs[10] = '{4'h0, 32'h0,  4'h8, 0, 0, 0, 32'h0,        0, 32'hA2, 0, 4'h0, 4'h0, 4'h7, 32'hDEADBEEF};
    vecs[11] = '{4'h0, 32'h0,  4'h8, 0, 0, 0, 32'h0,        0, 32'hA2, 0, 4'h0, 4'h0, 4'h7, 32'hDEADBEEF};
    vecs[12] = '{4'h0, 32'h0,  4'h0, 0, 0, 0, 32'h0,        0, 32'hA2, 0, 4'h0, 4'h0, 4'hF, 32'hDEADBEEF};

    // Reset with enter_in[0] held high; the held level must not be captured
    idleInputs();
    rst = 1'b1;
    enter_in = 4'h1;
    applyStimulus("reset0");
    applyStimulus("reset1");
    chk("reset/in_ready", in_ready, 4'h0);
    chk("reset/out_ready", out_ready, 4'hF);
    rst = 1'b0;
    applyStimulus("heldLevel");
    chk("heldLevel/in_ready", in_ready, 4'h0);

    // Directed vector table: channel 2 reads, channel 3 write handshake
    for (int i = 0; i < 13; i++) begin
      enter_in  = vecs[i].enIn;
      dev_in    = {4{vecs[i].din}};
      done_out  = vecs[i].done;
      cpu_rd    = vecs[i].rd;
      cpu_wr    = vecs[i].wr;
      cpu_chan  = vecs[i].chan;
      cpu_wdata = vecs[i].wdata;
      applyStimulus($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/rvalid", i), cpu_rvalid, vecs[i].expRvalid);
      chk($sformatf("vec%0d/rdata", i), cpu_rdata, vecs[i].expRdata);
      chk($sformatf("vec%0d/wr_err", i), wr_err, vecs[i].expWrErr);
      chk($sformatf("vec%0d/in_ready", i), in_ready, vecs[i].expInReady);
      chk($sformatf("vec%0d/enter_out", i), enter_out, vecs[i].expEnterOut);
      chk($sformatf("vec%0d/out_ready", i), out_ready, vecs[i].expOutReady);
      chk($sformatf("vec%0d/dout3", i), dev_out[127:96], vecs[i].expDout3);
    end
    idleInputs();

    // Five edges into channel 1: four stored, the fifth sets overflow
    for (int k = 0; k < 5; k++) begin
      enter_in = 4'h2;
      dev_in = '0;
      dev_in[63:32] = 32'hB000_0000 + 32'(k);
      applyStimulus("ovfPush");
      enter_in = 4'h0;
      applyStimulus("ovfGap");
    end
    chk("ovf/overflow1", overflow[1], 1'b1);
    chk("ovf/in_ready1", in_ready[1], 1'b1);
    cpu_rd = 1'b1; cpu_chan = 2'd1;
    applyStimulus("ovfRead");
    chk("ovfRead/rdata", cpu_rdata, 32'hB000_0000);
    chk("ovfRead/overflow1", overflow[1], 1'b0);
    cpu_rd = 1'b0;

    // Refill to full, then push and pop the same channel in one cycle
    enter_in = 4'h2; dev_in[63:32] = 32'hB000_0005;
    applyStimulus("fillPush");
    enter_in = 4'h0;
    applyStimulus("fillGap");
    enter_in = 4'h2; dev_in[63:32] = 32'hB000_0006;
    cpu_rd = 1'b1; cpu_chan = 2'd1;
    applyStimulus("pushPop");
    chk("pushPop/rdata", cpu_rdata, 32'hB000_0001);
    chk("pushPop/overflow1", overflow[1], 1'b0);
    enter_in = 4'h0;
    begin
      logic [31:0] drain [4];
      drain[0] = 32'hB000_0002; drain[1] = 32'hB000_0003;
      drain[2] = 32'hB000_0005; drain[3] = 32'hB000_0006;
      for (int k = 0; k < 4; k++) begin
        applyStimulus("drain");
        chk($sformatf("drain%0d/rdata", k), cpu_rdata, drain[k]);
        chk($sformatf("drain%0d/rvalid", k), cpu_rvalid, 1'b1);
      end
    end
    cpu_rd = 1'b0;
    applyStimulus("drainEnd");
    chk("drainEnd/in_ready1", in_ready[1], 1'b0);

`ifdef IO_HUB_TIMEOUT_EN
    // Stalled handshake on channel 0 aborts after TO cycles; the next write clears the flag
    idleInputs();
    cpu_wr = 1'b1; cpu_chan = 2'd0; cpu_wdata = 32'h0000_00AA;
    applyStimulus("toWrite");
    cpu_wr = 1'b0;
    for (int k = 1; k < TO; k++) begin
      applyStimulus("toWait");
      chk($sformatf("toWait%0d/enter_out0", k), enter_out[0], 1'b1);
    end
    applyStimulus("toExpire");
    chk("toExpire/enter_out0", enter_out[0], 1'b0);
    chk("toExpire/timeout0", timeout[0], 1'b1);
    cpu_wr = 1'b1; cpu_wdata = 32'h0000_00BB;
    applyStimulus("toRewrite");
    chk("toRewrite/timeout0", timeout[0], 1'b0);
    cpu_wr = 1'b0; done_out = 4'h1;
    applyStimulus("toAck");
    done_out = 4'h0;
    applyStimulus("toRelease");
`endif

    // Randomized traffic checked against the model
    idleInputs();
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 63) == 0);
      enter_in  = 4'($urandom);
      dev_in    = {$urandom, $urandom, $urandom, $urandom};
      done_out  = 4'($urandom);
      cpu_chan  = 2'($urandom);
      cpu_rd    = ($urandom_range(0, 1) == 1);
      cpu_wr    = ($urandom_range(0, 3) == 0);
      cpu_wdata = $urandom;
      applyStimulus("rand");
    end
    rst = 1'b0;
    idleInputs();
    applyStimulus("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
